// File: rtl/if_id_stage_ctrl_pkg.sv
// if_id_stage_ctrl_pkg
//   Shared pipeline defines: opcode constants, register-file address width,
//   IF/ID control action encoding, the NOP word and the action priority helper.
package if_id_stage_ctrl_pkg;

  localparam int REG_FILE_ADDR_LEN = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;

  // All-zero word is what IF/ID carries as a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    CTRL_RUN    = 2'd0,
    CTRL_STALL  = 2'd1,
    CTRL_FLUSH  = 2'd2,
    CTRL_FREEZE = 2'd3
  } ctrl_state_t;

  // Freeze beats flush beats stall beats run.
  function automatic ctrl_state_t next_action(input logic mem_busy,
                                              input logic flush_req,
                                              input logic hazard);
    if (mem_busy)       return CTRL_FREEZE;
    else if (flush_req) return CTRL_FLUSH;
    else if (hazard)    return CTRL_STALL;
    else                return CTRL_RUN;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// sat_counter16
//   16-bit event counter that increments when inc is high and sticks at 0xFFFF.
//   Ports: clk, rst_n (async active-low), inc, count[15:0].
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/if_id_stage_ctrl.sv
// if_id_stage_ctrl
//   IF/ID pipeline register with its hazard, branch-flush and memory-freeze
//   control, event counters and a consecutive-stall watchdog.
//   Inputs : clk, rst_n, pc_in, instr_in, hazard_detected, branch_taken, mem_busy
//   Outputs: pc_out, instr_out, valid_out (registered IF/ID contents)
//            pc_write_en, id_ex_bubble (combinational control)
//            ctrl_state, stall_count, flush_count, stall_timeout (registered status)
//
//   state  | meaning
//   RUN    | IF/ID loads the fetched word, PC advances
//   STALL  | IF/ID and PC hold, bubble into ID/EX
//   FLUSH  | IF/ID loads a NOP, PC advances to the redirect target, bubble into ID/EX
//   FREEZE | everything holds while data memory is busy
module if_id_stage_ctrl
  import if_id_stage_ctrl_pkg::*;
#(
  parameter int PC_LEN      = 32,
  parameter int INSTR_LEN   = 32,
  parameter int STALL_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PC_LEN-1:0]    pc_in,
  input  logic [INSTR_LEN-1:0] instr_in,
  input  logic                 hazard_detected,
  input  logic                 branch_taken,
  input  logic                 mem_busy,
  output logic [PC_LEN-1:0]    pc_out,
  output logic [INSTR_LEN-1:0] instr_out,
  output logic                 valid_out,
  output logic                 pc_write_en,
  output logic                 id_ex_bubble,
  output logic [1:0]           ctrl_state,
  output logic [15:0]          stall_count,
  output logic [15:0]          flush_count,
  output logic                 stall_timeout
);

  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT      = CW'(STALL_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1   = CW'(STALL_LIMIT - 1);
  localparam logic [INSTR_LEN-1:0] NOP = INSTR_LEN'(NOP_INSTR);

  ctrl_state_t   act;
  ctrl_state_t   state_q;
  logic          pending_flush;
  logic [CW-1:0] consec;

  // A branch seen during a freeze is remembered so the flush is not lost.
  assign act          = next_action(mem_busy, branch_taken | pending_flush, hazard_detected);
  assign pc_write_en  = (act == CTRL_RUN) || (act == CTRL_FLUSH);
  assign id_ex_bubble = (act == CTRL_FLUSH) || (act == CTRL_STALL);
  assign ctrl_state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CTRL_RUN;
      pc_out        <= '0;
      instr_out     <= '0;
      valid_out     <= 1'b0;
      pending_flush <= 1'b0;
      consec        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state_q <= act;
      case (act)
        CTRL_FREEZE: begin
          // Consecutive-stall count holds across a freeze.
          if (branch_taken) pending_flush <= 1'b1;
        end
        CTRL_FLUSH: begin
          pc_out        <= pc_in;
          instr_out     <= NOP;
          valid_out     <= 1'b0;
          pending_flush <= 1'b0;
          consec        <= '0;
        end
        CTRL_STALL: begin
          if (consec != LIMIT) consec <= consec + CW'(1);
          if (consec >= LIMIT_M1) stall_timeout <= 1'b1;
        end
        default: begin
          pc_out    <= pc_in;
          instr_out <= instr_in;
          valid_out <= 1'b1;
          consec    <= '0;
        end
      endcase
    end
  end

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act == CTRL_STALL),
    .count (stall_count)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act == CTRL_FLUSH),
    .count (flush_count)
  );

endmodule

// File: doc/if_id_stage_ctrl.md
IF_ID_STAGE_CTRL -- requirements
Module: if_id_stage_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter: PC_LEN, default 32, width of program-counter values.
REQ-003 Parameter: INSTR_LEN, default 32, width of instruction words.
REQ-004 Parameter: STALL_LIMIT, default 8, consecutive hazard-stall cycles before the watchdog fires.
REQ-005 clk  in  1  pipeline clock, rising-edge active.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 pc_in  in  PC_LEN  PC of the word fetched this cycle.
REQ-008 instr_in  in  INSTR_LEN  instruction fetched this cycle.
REQ-009 hazard_detected  in  1  stall request from the hazard detection unit, combinational for the decode-stage instruction.
REQ-010 branch_taken  in  1  branch resolved taken; younger instructions are wrong-path.
REQ-011 mem_busy  in  1  data memory not ready; the whole front end freezes.
REQ-012 pc_out  out  PC_LEN  registered PC presented to decode.
REQ-013 instr_out  out  INSTR_LEN  registered instruction presented to decode.
REQ-014 valid_out  out  1  instr_out is a real instruction, not a bubble.
REQ-015 pc_write_en  out  1  fetch PC register may advance.
REQ-016 id_ex_bubble  out  1  ID/EX register loads a NOP this cycle.
REQ-017 ctrl_state  out  2  registered action of the previous cycle: RUN=0, STALL=1, FLUSH=2, FREEZE=3.
REQ-018 stall_count  out  16  hazard-stall cycle counter.
REQ-019 flush_count  out  16  flush event counter.
REQ-020 stall_timeout  out  1  sticky watchdog error flag.

Function
REQ-021 Per-cycle action priority SHALL be FREEZE (mem_busy) > FLUSH (branch_taken or pending_flush) > STALL (hazard_detected) > RUN.
REQ-022 FREEZE: pc_write_en=0, id_ex_bubble=0, IF/ID registers hold, counters hold.
REQ-023 branch_taken during FREEZE SHALL set an internal pending_flush; the flush executes on the first cycle with mem_busy=0 and clears pending_flush.
REQ-024 FLUSH: pc_write_en=1, IF/ID loads instr_out=0 (NOP) and valid_out=0, id_ex_bubble=1, flush_count increments; hazard_detected is ignored that cycle.
REQ-025 STALL: pc_write_en=0, IF/ID holds, id_ex_bubble=1, stall_count increments.
REQ-026 RUN: pc_write_en=1, IF/ID loads pc_in, instr_in, valid_out=1; id_ex_bubble=0.
REQ-027 pc_write_en and id_ex_bubble SHALL be combinational from the current inputs and pending_flush; all other outputs SHALL be registered.
REQ-028 IF/ID update latency SHALL be one clock: inputs sampled on edge N appear on pc_out/instr_out after edge N.
REQ-029 ctrl_state SHALL encode the action taken on the most recent edge.
REQ-030 Counters SHALL saturate at 0xFFFF, never wrap.
REQ-031 A consecutive-STALL counter SHALL reset on any non-STALL cycle except FREEZE, which holds it; reaching STALL_LIMIT SHALL set stall_timeout, cleared only by reset.

Reset
REQ-032 On rst_n=0: pc_out=0, instr_out=0, valid_out=0, ctrl_state=RUN, stall_count=0, flush_count=0, stall_timeout=0, pending_flush=0, consecutive counter=0.
REQ-033 Reset asserted mid-stall or with pending_flush SHALL discard all pending state immediately, independent of clk.
REQ-034 First edge after reset deassertion SHALL behave as a normal cycle per REQ-021.

Structure
REQ-035 ctrl_state encoding and the NOP constant SHALL reside in the shared defines alongside the existing OP_ and REG_FILE_ADDR_LEN definitions.
REQ-036 One sub-module, sat_counter16 (increment-enable, saturating at 0xFFFF), SHALL be instantiated for stall_count and flush_count.

Verification
REQ-037 RUN: pc_in=0x10, instr_in=0xA5A5A5A5, no requests -> after one edge pc_out=0x10, instr_out=0xA5A5A5A5, valid_out=1, pc_write_en=1.
REQ-038 Stall: hazard_detected=1 for 2 cycles -> pc_write_en=0, id_ex_bubble=1, IF/ID held, stall_count=2, ctrl_state=STALL.
REQ-039 Flush beats stall: branch_taken=1 and hazard_detected=1 together -> instr_out=0, valid_out=0, id_ex_bubble=1, flush_count=1, stall_count unchanged.
REQ-040 Deferred flush: branch_taken=1 during mem_busy=1 for 3 cycles -> outputs held 3 cycles, flush on the first mem_busy=0 cycle, flush_count=1.
REQ-041 Watchdog: hazard_detected=1 for 8 cycles -> stall_timeout=1 and it stays 1 after hazard drops until rst_n=0.
REQ-042 Async reset: rst_n low mid-stall, between clock edges -> all outputs reach REQ-032 values immediately, with no clock edge.
